// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with one byte-masked write port, two registered
// read ports and a sequential clear engine that zeroes one entry per cycle.
// Optional feature: define REG_FILE_BYPASS_EN to return byte-merged write data
// on a read of the address being written in the same cycle.
module reg_file_mp #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                WrEn,
   input  logic [ADDR_W-1:0]   WrAddr,
   input  logic [DATA_W-1:0]   WrData,
   input  logic [DATA_W/8-1:0] WrBe,
   input  logic                RdEn0,
   input  logic                RdEn1,
   input  logic [ADDR_W-1:0]   RdAddr0,
   input  logic [ADDR_W-1:0]   RdAddr1,
   output logic [DATA_W-1:0]   RdData0,
   output logic [DATA_W-1:0]   RdData1,
   output logic                RdValid0,
   output logic                RdValid1,
   input  logic                Clr,
   output logic                Busy,
   output logic                AddrErr
);

   localparam int unsigned       NB        = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_in_rng;
   logic              rd0_in_rng;
   logic              rd1_in_rng;
   logic              wr_block;
   logic              wr_ok;
   logic              wr_oor_err;
   logic [DATA_W-1:0] rd_word0;
   logic [DATA_W-1:0] rd_word1;

   assign Busy = (state == ST_CLEAR);

   // Address range checks and write acceptance
   always_comb begin
      wr_in_rng  = ({1'b0, WrAddr}  < DEPTH_EXT);
      rd0_in_rng = ({1'b0, RdAddr0} < DEPTH_EXT);
      rd1_in_rng = ({1'b0, RdAddr1} < DEPTH_EXT);
      // In IDLE a Clr blocks a coincident write; in CLEAR Busy blocks it.
      wr_block   = Busy || Clr;
      wr_ok      = WrEn && !wr_block && wr_in_rng;
      // Writes dropped for Busy/Clr never flag an address error.
      wr_oor_err = WrEn && !wr_block && !wr_in_rng;
   end

`ifdef REG_FILE_BYPASS_EN
   logic [DATA_W-1:0] wr_merged;

   // Byte-merge of the incoming write over the current entry contents
   always_comb begin
      wr_merged = wr_in_rng ? mem[WrAddr] : '0;
      for (int unsigned b = 0; b < NB; b++) begin
         if (WrBe[b]) begin
            wr_merged[8*b +: 8] = WrData[8*b +: 8];
         end
      end
   end
`endif

   // Read word selection for both ports (zero when out of range)
   always_comb begin
      rd_word0 = rd0_in_rng ? mem[RdAddr0] : '0;
      rd_word1 = rd1_in_rng ? mem[RdAddr1] : '0;
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (WrAddr == RdAddr0)) begin
         rd_word0 = wr_merged;
      end
      if (wr_ok && (WrAddr == RdAddr1)) begin
         rd_word1 = wr_merged;
      end
`endif
   end

   // Clear FSM: walk the counter over entries 0..DEPTH-1, one per cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_IDLE;
         clr_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Clr) begin
                  state   <= ST_CLEAR;
                  clr_cnt <= '0;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt == LAST_IDX) begin
                  state   <= ST_IDLE;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               clr_cnt <= '0;
            end
         endcase
      end
   end

   // Storage: reset/clear zeroing and byte-lane writes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == ST_CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (WrBe[b]) begin
               mem[WrAddr][8*b +: 8] <= WrData[8*b +: 8];
            end
         end
      end
   end

   // Registered read ports: data held when idle, valid is a one-cycle pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RdData0  <= '0;
         RdData1  <= '0;
         RdValid0 <= 1'b0;
         RdValid1 <= 1'b0;
      end else begin
         RdValid0 <= RdEn0;
         RdValid1 <= RdEn1;
         if (RdEn0) begin
            RdData0 <= rd_word0;
         end
         if (RdEn1) begin
            RdData1 <= rd_word1;
         end
      end
   end

   // Address error pulse for any out-of-range read or accepted-path write
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         AddrErr <= 1'b0;
      end else begin
         AddrErr <= (RdEn0 && !rd0_in_rng) || (RdEn1 && !rd1_in_rng) || wr_oor_err;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp, with an 8-entry instance and
// a 6-entry instance sharing the same stimulus.
module tb_reg_file_mp;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WrEn;
   logic [2:0]  WrAddr;
   logic [15:0] WrData;
   logic [1:0]  WrBe;
   logic        RdEn0;
   logic        RdEn1;
   logic [2:0]  RdAddr0;
   logic [2:0]  RdAddr1;
   logic        Clr;

   logic [15:0] RdData0, RdData1;
   logic        RdValid0, RdValid1, Busy, AddrErr;
   logic [15:0] RdData0_6, RdData1_6;
   logic        RdValid0_6, RdValid1_6, Busy_6, AddrErr_6;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 CLK = ~CLK;

   reg_file_mp #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
      .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .WrBe(WrBe), .RdEn0(RdEn0), .RdEn1(RdEn1), .RdAddr0(RdAddr0),
      .RdAddr1(RdAddr1), .RdData0(RdData0), .RdData1(RdData1),
      .RdValid0(RdValid0), .RdValid1(RdValid1), .Clr(Clr), .Busy(Busy),
      .AddrErr(AddrErr)
   );

   reg_file_mp #(.DATA_W(16), .DEPTH(6), .ADDR_W(3)) dut6 (
      .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .WrBe(WrBe), .RdEn0(RdEn0), .RdEn1(RdEn1), .RdAddr0(RdAddr0),
      .RdAddr1(RdAddr1), .RdData0(RdData0_6), .RdData1(RdData1_6),
      .RdValid0(RdValid0_6), .RdValid1(RdValid1_6), .Clr(Clr), .Busy(Busy_6),
      .AddrErr(AddrErr_6)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      WrEn  = 1'b0;
      RdEn0 = 1'b0;
      RdEn1 = 1'b0;
      Clr   = 1'b0;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      WrEn = 1'b1; WrAddr = a; WrData = d; WrBe = be;
      tick();
      WrEn = 1'b0;
   endtask

   int          cycles;
   logic        err_seen;
   logic [15:0] exp_bypass;

   initial begin
      RST = 1'b1;
      idle_inputs();
      WrAddr = '0; WrData = '0; WrBe = '0; RdAddr0 = '0; RdAddr1 = '0;
      #1;
      check_val("rst_rddata0", RdData0, 0);
      check_val("rst_rddata1", RdData1, 0);
      check_val("rst_rdvalid0", RdValid0, 0);
      check_val("rst_busy", Busy, 0);
      check_val("rst_addrerr", AddrErr, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // Basic write/read latency
      write_word(3'd3, 16'hA5A5, 2'b11);
      RdEn0 = 1'b1; RdAddr0 = 3'd3;
      tick();
      check_val("rd3_data", RdData0, 16'hA5A5);
      check_val("rd3_valid", RdValid0, 1);
      check_val("rd3_addrerr", AddrErr, 0);
      RdEn0 = 1'b0;
      tick();
      check_val("hold_valid", RdValid0, 0);
      check_val("hold_data", RdData0, 16'hA5A5);

      // Byte-lane write, both ports concurrently
      write_word(3'd2, 16'h1234, 2'b11);
      write_word(3'd2, 16'hFF00, 2'b10);
      RdEn0 = 1'b1; RdAddr0 = 3'd3; RdEn1 = 1'b1; RdAddr1 = 3'd2;
      tick();
      check_val("be_merge", RdData1, 16'hFF34);
      check_val("conc_rd0", RdData0, 16'hA5A5);
      check_val("conc_valid1", RdValid1, 1);
      RdAddr0 = 3'd2;
      tick();
      check_val("same_addr0", RdData0, 16'hFF34);
      check_val("same_addr1", RdData1, 16'hFF34);
      idle_inputs();

      // Same-cycle read of the address being written
      write_word(3'd5, 16'h1111, 2'b11);
`ifdef REG_FILE_BYPASS_EN
      exp_bypass = 16'hBEEF;
`else
      exp_bypass = 16'h1111;
`endif
      WrEn = 1'b1; WrAddr = 3'd5; WrData = 16'hBEEF; WrBe = 2'b11;
      RdEn0 = 1'b1; RdAddr0 = 3'd5;
      tick();
      WrEn = 1'b0;
      check_val("rw_same", RdData0, {16'h0, exp_bypass});
      tick();
      check_val("rw_after", RdData0, 16'hBEEF);
      idle_inputs();

      // Out-of-range accesses on the 6-entry instance
      write_word(3'd7, 16'hDEAD, 2'b11);
      check_val("oor_wr_err6", AddrErr_6, 1);
      check_val("oor_wr_err8", AddrErr, 0);
      tick();
      check_val("oor_wr_pulse", AddrErr_6, 0);
      RdEn0 = 1'b1; RdAddr0 = 3'd5; RdEn1 = 1'b1; RdAddr1 = 3'd3;
      tick();
      check_val("oor_keep5", RdData0_6, 16'hBEEF);
      check_val("oor_keep3", RdData1_6, 16'hA5A5);
      check_val("inrng_noerr", AddrErr_6, 0);
      RdEn1 = 1'b0; RdAddr0 = 3'd6;
      tick();
      check_val("oor_rd_data", RdData0_6, 0);
      check_val("oor_rd_valid", RdValid0_6, 1);
      check_val("oor_rd_err", AddrErr_6, 1);
      idle_inputs();
      tick();

      // Fill, then sequential clear
      for (int i = 0; i < 8; i++) begin
         write_word(3'(i), 16'((i + 1) * 16'h1111), 2'b11);
      end
      RdEn0 = 1'b1; RdAddr0 = 3'd6;
      tick();
      check_val("fill6", RdData0, 16'h7777);
      idle_inputs();
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      cycles = 0;
      err_seen = 1'b0;
      while (Busy && cycles < 20) begin
         cycles++;
         idle_inputs();
         if (cycles == 1) begin RdEn1 = 1'b1; RdAddr1 = 3'd7; end
         if (cycles == 2) begin RdEn0 = 1'b1; RdAddr0 = 3'd0; end
         if (cycles == 3) Clr = 1'b1;
         if (cycles == 6) begin WrEn = 1'b1; WrAddr = 3'd0; WrData = 16'h5555; WrBe = 2'b11; end
         tick();
         if (AddrErr) err_seen = 1'b1;
         if (cycles == 1) check_val("clr_rd_old", RdData1, 16'h8888);
         if (cycles == 2) check_val("clr_rd_zero", RdData0, 0);
      end
      idle_inputs();
      check_val("busy_cycles", cycles, 8);
      check_val("clr_no_err", err_seen, 0);
      for (int i = 0; i < 8; i++) begin
         RdEn0 = 1'b1; RdAddr0 = 3'(i);
         tick();
         check_val($sformatf("clr_zero%0d", i), RdData0, 0);
      end
      idle_inputs();

      // Reset in the middle of a clear
      write_word(3'd6, 16'h6666, 2'b11);
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      RdEn0 = 1'b1; RdAddr0 = 3'd6;
      repeat (3) tick();
      check_val("mid_busy", Busy, 1);
      check_val("mid_rd6", RdData0, 16'h6666);
      RST = 1'b1;
      #2;
      check_val("arst_busy", Busy, 0);
      check_val("arst_data0", RdData0, 0);
      check_val("arst_valid0", RdValid0, 0);
      check_val("arst_err", AddrErr, 0);
      idle_inputs();
      #2 RST = 1'b0;
      write_word(3'd1, 16'h1357, 2'b11);
      RdEn0 = 1'b1; RdAddr0 = 3'd1; RdEn1 = 1'b1; RdAddr1 = 3'd6;
      tick();
      check_val("post_rst_wr", RdData0, 16'h1357);
      check_val("post_rst_zero6", RdData1, 0);
      check_val("post_rst_busy", Busy, 0);
      idle_inputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (2..256).
REQ-003 The block SHALL have parameter ADDR_W, default 3, address width, with 2**ADDR_W >= DEPTH.
REQ-004 The block SHALL have port CLK, input, 1, single clock; all state changes on rising edge.
REQ-005 The block SHALL have port RST, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port WrEn, input, 1, write request.
REQ-007 The block SHALL have port WrAddr, input, ADDR_W, write address.
REQ-008 The block SHALL have port WrData, input, DATA_W, write data.
REQ-009 The block SHALL have port WrBe, input, DATA_W/8, byte-lane write enables; bit i covers bits 8i+7..8i.
REQ-010 The block SHALL have ports RdEn0 and RdEn1, input, 1 each, read requests, ports 0 and 1.
REQ-011 The block SHALL have ports RdAddr0 and RdAddr1, input, ADDR_W each, read addresses.
REQ-012 The block SHALL have ports RdData0 and RdData1, output, DATA_W each, registered read data.
REQ-013 The block SHALL have ports RdValid0 and RdValid1, output, 1 each, one-cycle read-data-valid pulses.
REQ-014 The block SHALL have port Clr, input, 1, request to zero all entries.
REQ-015 The block SHALL have port Busy, output, 1, high while the clear sequence runs.
REQ-016 The block SHALL have port AddrErr, output, 1, one-cycle pulse on any out-of-range access.

Function
REQ-017 Write: WrEn=1, Busy=0, Clr=0, WrAddr<DEPTH at edge k SHALL update only the lanes with WrBe=1; the new value is visible to reads sampled at edge k+1.
REQ-018 Read port n: RdEn_n=1 at edge k SHALL drive RdData_n=entry[RdAddr_n] and RdValid_n=1 after edge k; latency 1 cycle.
REQ-019 RdEn_n=0 SHALL hold RdData_n at its last value and clear RdValid_n.
REQ-020 Both read ports SHALL operate independently and concurrently, same or different addresses.
REQ-021 Read address >= DEPTH SHALL return RdData_n=0 with RdValid_n=1 and pulse AddrErr.
REQ-022 Write address >= DEPTH SHALL drop the write, leave every entry unchanged and pulse AddrErr.
REQ-023 Read and write to the same address in the same cycle without the bypass feature SHALL return the pre-write contents.
REQ-024 Clear FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on Clr=1; a counter zeroes entry 0..DEPTH-1, one per cycle; CLEAR->IDLE after entry DEPTH-1.
REQ-025 Busy SHALL be high for exactly DEPTH cycles, starting the cycle after Clr is sampled.
REQ-026 Clr during CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-027 Writes with Busy=1, or coincident with Clr=1 in IDLE, SHALL be dropped; AddrErr is not pulsed for these drops.
REQ-028 Reads during CLEAR SHALL be serviced normally and SHALL return current contents: zero for entries already cleared, old data otherwise.

Reset
REQ-029 RST=1 SHALL, asynchronously, zero all entries, RdData0/1, RdValid0/1, Busy, AddrErr and the clear counter, and force IDLE.
REQ-030 RST asserted mid-CLEAR SHALL abort the sequence; after release the FSM is in IDLE and the first edge accepts requests.

Configuration
REQ-031 With macro REG_FILE_BYPASS_EN defined, a same-cycle read of the address being written SHALL return the byte-merged new data: WrData on lanes with WrBe=1, old data on the rest.
REQ-032 Without REG_FILE_BYPASS_EN, same-address reads SHALL follow REQ-023; all other behaviour is identical.

Verification
REQ-033 Reset, write 0xA5A5 @3 WrBe=11, then read0 @3 -> RdData0=0xA5A5 and RdValid0=1 one cycle after RdEn0.
REQ-034 Entry 2=0x1234; write 0xFF00 @2 with WrBe=10 -> read returns 0xFF34.
REQ-035 Write 0xBEEF @5 with RdEn0 @5 in the same cycle -> RdData0=old value; with REG_FILE_BYPASS_EN -> 0xBEEF.
REQ-036 DEPTH=6: write @7 -> AddrErr pulses 1 cycle, contents unchanged; read @6 -> RdData=0, AddrErr=1.
REQ-037 Fill all entries, pulse Clr -> Busy high 8 cycles; WrEn during Busy is dropped; all reads return 0 afterwards.
REQ-038 Assert RST at clear step 3 -> all outputs 0 and Busy=0 at once; write @1 after release succeeds.
